// File: rtl/img_loader_pkg.sv
// Shared types and constants for the image loader.
package img_loader_pkg;

    localparam int unsigned IMG_WIDTH_DEF   = 16;
    localparam int unsigned ADDR_WIDTH_DEF  = 10;
    localparam int unsigned FRAME_WORDS_DEF = 32'(1) << ADDR_WIDTH_DEF;

    // Loader control states; PAD is only reachable with s_last checking built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2,
        PAD  = 2'd3
    } state_e;

    // Bank currently being filled.
    typedef enum logic {
        BANK1 = 1'b0,
        BANK2 = 1'b1
    } bank_sel_e;

    // Width of a word counter that must hold 0 .. words-1.
    function automatic int unsigned cnt_width(input int unsigned words);
        return (words <= 32'd2) ? 32'd1 : 32'($clog2(words));
    endfunction

endpackage

// File: rtl/img_loader_bank_flag.sv
// Per-bank "frame complete" flag: set has priority over a refill request,
// and a request only clears a flag that is currently set.
module img_loader_bank_flag (
    input  logic clk,
    input  logic rst,
    input  logic set_full,
    input  logic req,
    output logic full,
    output logic full_nxt_c
);

    logic full_q;
    logic full_d;

    // Next flag value; a request against an empty bank has nothing to free.
    always_comb begin
        full_d = set_full | (full_q & ~req);
    end

    // Flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    assign full       = full_q;
    assign full_nxt_c = full_d;

endmodule

// File: rtl/img_loader.sv
// Streams pixel words into a ping-pong input SRAM and flags complete frames.
// Optional s_last framing check: define IMG_LOADER_LAST_CHECK_EN.
module img_loader
    import img_loader_pkg::*;
#(
    parameter int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [IMG_WIDTH-1:0]  s_data,
`ifdef IMG_LOADER_LAST_CHECK_EN
    input  logic                  s_last,
    output logic                  frame_err,
`endif
    output logic                  s_ready,
    input  logic                  img_request1,
    input  logic                  img_request2,
    output logic [IMG_WIDTH-1:0]  pre_data,
    output logic [ADDR_WIDTH-1:0] pre_addr,
    output logic                  pre_en1,
    output logic                  pre_en2,
    output logic                  pre_wr1,
    output logic                  pre_wr2,
    output logic                  pre_sram_full1,
    output logic                  pre_sram_full2
);

    localparam int unsigned     CNT_W    = cnt_width(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

    state_e                state_q, state_d;
    bank_sel_e             sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  en1_q, en1_d, en2_q, en2_d;
    logic                  wr1_q, wr1_d, wr2_q, wr2_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IMG_WIDTH-1:0]  data_q, data_d;
`ifdef IMG_LOADER_LAST_CHECK_EN
    logic                  frame_err_q, frame_err_d;
`endif

    logic accept_c;
    logic wr_en_c;
    logic set1_c, set2_c;
    logic full1_c, full2_c;
    logic full1_nxt_c, full2_nxt_c;

    assign accept_c = s_valid & s_ready_q;

    // Bank 1 full flag.
    img_loader_bank_flag u_flag1 (
        .clk        (clk),
        .rst        (rst),
        .set_full   (set1_c),
        .req        (img_request1),
        .full       (full1_c),
        .full_nxt_c (full1_nxt_c)
    );

    // Bank 2 full flag.
    img_loader_bank_flag u_flag2 (
        .clk        (clk),
        .rst        (rst),
        .set_full   (set2_c),
        .req        (img_request2),
        .full       (full2_c),
        .full_nxt_c (full2_nxt_c)
    );

    // Next-state, write strobe and flag-set decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en1_d   = 1'b0;
        en2_d   = 1'b0;
        wr1_d   = 1'b1;
        wr2_d   = 1'b1;
        wr_en_c = 1'b0;
        set1_c  = 1'b0;
        set2_c  = 1'b0;
`ifdef IMG_LOADER_LAST_CHECK_EN
        frame_err_d = frame_err_q;
`endif

        case (state_q)
            IDLE: begin
                state_d = FILL;
            end
            FILL: begin
                if (accept_c) begin
                    wr_en_c = 1'b1;
                    addr_d  = ADDR_WIDTH'(cnt_q);
                    data_d  = s_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = SWAP;
                    end
`ifdef IMG_LOADER_LAST_CHECK_EN
                    if (s_last != (cnt_q == LAST_CNT)) begin
                        frame_err_d = 1'b1;
                    end
                    if (s_last && (cnt_q != LAST_CNT)) begin
                        state_d = PAD;
                    end
`endif
                end
            end
            SWAP: begin
                // The last write strobe was the previous cycle, so the frame is in SRAM.
                set1_c  = (sel_q == BANK1);
                set2_c  = (sel_q == BANK2);
                sel_d   = (sel_q == BANK1) ? BANK2 : BANK1;
                cnt_d   = '0;
                state_d = FILL;
            end
            PAD: begin
`ifdef IMG_LOADER_LAST_CHECK_EN
                wr_en_c = 1'b1;
                addr_d  = ADDR_WIDTH'(cnt_q);
                data_d  = IMG_WIDTH'(0);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = SWAP;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_en_c) begin
            if (sel_q == BANK1) begin
                en1_d = 1'b1;
                wr1_d = 1'b0;
            end else begin
                en2_d = 1'b1;
                wr2_d = 1'b0;
            end
        end
    end

    // Ready is registered from the bank that will be selected next cycle.
    always_comb begin
        s_ready_d = 1'b0;
        if (state_d == FILL) begin
            s_ready_d = (sel_d == BANK1) ? ~full1_nxt_c : ~full2_nxt_c;
        end
    end

    // Control and SRAM interface registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sel_q       <= BANK1;
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            en1_q       <= 1'b0;
            en2_q       <= 1'b0;
            wr1_q       <= 1'b1;
            wr2_q       <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef IMG_LOADER_LAST_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            s_ready_q   <= s_ready_d;
            en1_q       <= en1_d;
            en2_q       <= en2_d;
            wr1_q       <= wr1_d;
            wr2_q       <= wr2_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef IMG_LOADER_LAST_CHECK_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign s_ready        = s_ready_q;
    assign pre_en1        = en1_q;
    assign pre_en2        = en2_q;
    assign pre_wr1        = wr1_q;
    assign pre_wr2        = wr2_q;
    assign pre_addr       = addr_q;
    assign pre_data       = data_q;
    assign pre_sram_full1 = full1_c;
    assign pre_sram_full2 = full2_c;
`ifdef IMG_LOADER_LAST_CHECK_EN
    assign frame_err      = frame_err_q;
`endif

endmodule
